// File: rtl/stopwatch_digit_driver.sv
// stopwatch_digit_driver
//   Stopwatch timebase and four-digit BCD counter (M:SS.t). The digits are
//   time-multiplexed onto a single 4-bit code bus with active-low anode
//   strobes for the board's seven-segment decoder.
//   Decoder code map: 0-9 digits, 10 dash, 11 blank.
//
// Ports
//   clk_i         system clock, rising edge
//   reset_i       asynchronous active-high reset, clears all state
//   start_stop_i  one-cycle pulse: IDLE->RUN, RUN<->PAUSE (ignored in DONE)
//   clear_i       one-cycle pulse: zero the count, back to IDLE (beats start_stop_i)
//   digit_code_o  code of the currently scanned digit
//   anode_o       one-hot active-low enable; [0] tenths, [1] ones, [2] tens, [3] minutes
//   running_o     high while in RUN
//   overflow_o    high while in DONE (terminal count 9:59.9 was reached)
//
// Requires CLK_HZ/TICK_HZ >= 2 and CLK_HZ/SCAN_HZ >= 1.

// One BCD digit of the chain. Wraps MAX->0 on increment; clear has priority.
// nxt_o is the next-state value, zero-extended to the 4-bit code width, so
// the display register can show the count on the same edge it changes.
module stopwatch_bcd_cell #(
  parameter int W   = 4,
  parameter int MAX = 9
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic       max_o,
  output logic [3:0] nxt_o
);
  logic [W-1:0] val_q, val_d;

  assign max_o = (val_q == W'(MAX));

  always_comb begin
    val_d = val_q;
    if (clr_i)      val_d = '0;
    else if (inc_i) val_d = max_o ? '0 : val_q + 1'b1;
  end

  assign nxt_o = 4'(val_d);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) val_q <= '0;
    else         val_q <= val_d;
  end
endmodule

module stopwatch_digit_driver #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 10,
  parameter int SCAN_HZ = 1000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_stop_i,
  input  logic       clear_i,
  output logic [3:0] digit_code_o,
  output logic [3:0] anode_o,
  output logic       running_o,
  output logic       overflow_o
);
  localparam int D  = CLK_HZ / TICK_HZ;
  localparam int S  = CLK_HZ / SCAN_HZ;
  localparam int TW = $clog2(D);
  // S == 1 would give a zero-width counter; keep one bit that stays at 0.
  localparam int SW = (S > 1) ? $clog2(S) : 1;

  localparam logic [3:0] CODE_DASH = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q,  tick_d;
  logic [SW-1:0]   scan_q,  scan_d;
  logic [1:0]      idx_q,   idx_d;
  logic [3:0]      anode_q, anode_d;
  logic [3:0]      code_q,  code_d;
  logic            running_q, running_d;
  logic            overflow_q, overflow_d;

  logic            tick_wrap, scan_wrap, adv, terminal;
  logic [3:0]      max_w, inc_w;
  logic [3:0][3:0] dig_nxt;

  // ---------------------------------------------------------------------
  // Digit chain: tenths(0..9) -> ones(0..9) -> tens(0..5) -> minutes(0..9).
  // The whole carry ripples combinationally so every wrap lands on one edge.
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < 4; g++) begin : g_digit
    localparam int W   = (g == 2) ? 3 : 4;
    localparam int MAX = (g == 2) ? 5 : 9;

    if (g == 0) begin : g_first
      assign inc_w[g] = adv;
    end else begin : g_rest
      assign inc_w[g] = inc_w[g-1] & max_w[g-1];
    end

    stopwatch_bcd_cell #(.W(W), .MAX(MAX)) u_cell (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (clear_i),
      .inc_i   (inc_w[g]),
      .max_o   (max_w[g]),
      .nxt_o   (dig_nxt[g])
    );
  end

  // 9:59.9 -- the next tick would wrap the display, so it stops instead.
  assign terminal  = &max_w;
  assign tick_wrap = (tick_q == TW'(D - 1));
  assign scan_wrap = (scan_q == SW'(S - 1));

  // ---------------------------------------------------------------------
  // Control FSM and tick prescaler.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    adv     = 1'b0;
    if (clear_i) begin
      // clear outranks start_stop in the same cycle
      state_d = S_IDLE;
      tick_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_stop_i) begin
            state_d = S_RUN;
            tick_d  = '0;
          end
        end
        S_RUN: begin
          if (start_stop_i) begin
            // pause freezes both the digits and the prescaler phase
            state_d = S_PAUSE;
          end else if (tick_wrap) begin
            tick_d = '0;
            if (terminal) state_d = S_DONE;
            else          adv     = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_PAUSE: begin
          if (start_stop_i) begin
            // resume restarts a full tick period rather than the frozen phase
            state_d = S_RUN;
            tick_d  = '0;
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Scan and registered outputs. Everything is derived from next-state
  // values so anode, code and the flags change together on one edge.
  // ---------------------------------------------------------------------
  always_comb begin
    scan_d     = scan_wrap ? '0 : scan_q + 1'b1;
    idx_d      = scan_wrap ? idx_q + 1'b1 : idx_q;
    anode_d    = ~(4'b0001 << idx_d);
    code_d     = (state_d == S_DONE) ? CODE_DASH : dig_nxt[idx_d];
    running_d  = (state_d == S_RUN);
    overflow_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      scan_q     <= '0;
      idx_q      <= '0;
      anode_q    <= 4'b1110;
      code_q     <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      anode_q    <= anode_d;
      code_q     <= code_d;
      running_q  <= running_d;
      overflow_q <= overflow_d;
    end
  end

  assign digit_code_o = code_q;
  assign anode_o      = anode_q;
  assign running_o    = running_q;
  assign overflow_o   = overflow_q;
endmodule

// File: tb/tb_stopwatch_digit_driver.sv
// Bench for stopwatch_digit_driver with CLK_HZ=100, TICK_HZ=10, SCAN_HZ=50
// (tick every 10 cycles, scan index advances every 2 cycles).
// Stimulus schedules pulses on absolute cycle numbers (cyc = edges since
// reset release) and pushes the hand-computed display contents for chosen
// cycle windows into a scoreboard. The monitor pops and compares on each
// falling edge. Digits are written as 16'hMTOt (minutes, tens, ones, tenths);
// after edge n the scanned position is (n/2)%4.
module tb_stopwatch_digit_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ss  = 1'b0;
  logic       cl  = 1'b0;
  logic [3:0] code, anode;
  logic       running, overflow;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [15:0] dig;
    bit          run;
    bit          ovf;
  } exp_t;

  exp_t sb[$];

  stopwatch_digit_driver #(.CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(50)) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .start_stop_i (ss),
    .clear_i      (cl),
    .digit_code_o (code),
    .anode_o      (anode),
    .running_o    (running),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, act, want);
    end
  endtask

  task automatic span(input int c0, input int n, input logic [15:0] dig, input bit run, input bit ovf);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc = c0 + i; e.dig = dig; e.run = run; e.ovf = ovf;
      sb.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Drive the pulse so that the DUT samples it on edge number e.
  task automatic pulse_at(input int e, input bit s, input bit c);
    if (cyc >= e) begin
      tests++; fails++;
      $display("FAIL schedule cyc=%0d got=%0d want<%0d", e, cyc, e);
    end
    wait_cyc(e - 1);
    ss = s; cl = c;
    @(negedge clk);
    ss = 1'b0; cl = 1'b0;
  endtask

  // Monitor
  exp_t       m;
  logic [1:0] mi;
  logic [3:0] ea, ec;
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        m = sb.pop_front();
        if (m.cyc < cyc) begin
          tests++; fails++;
          $display("FAIL missed cyc=%0d got=%0d", m.cyc, cyc);
        end else begin
          mi = 2'((m.cyc >> 1) & 3);
          ea = ~(4'b0001 << mi);
          ec = m.ovf ? 4'd10 : m.dig[mi*4 +: 4];
          chk("anode",    cyc, anode,    ea);
          chk("code",     cyc, code,     ec);
          chk("running",  cyc, running,  m.run);
          chk("overflow", cyc, overflow, m.ovf);
        end
      end
    end
  end

  initial begin
    #800000;
    tests++; fails++;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    // reset state and idle scan rotation
    span(0, 15, 16'h0000, 0, 0);
    // start at edge 15: tenths 1 after edge 25, 2 after edge 35
    span(15, 10, 16'h0000, 1, 0);
    span(25, 10, 16'h0001, 1, 0);
    span(35, 8,  16'h0002, 1, 0);
    // 100 ticks -> 0:10.0
    span(1015, 8, 16'h0100, 1, 0);
    // clear at 1030 back to IDLE, restart at 1040
    span(1030, 10, 16'h0000, 0, 0);
    span(1040, 10, 16'h0000, 1, 0);
    span(1050, 8,  16'h0001, 1, 0);
    // pause at 1397 on 0:03.5, resume at 1447, next tick exactly at 1457
    span(1390, 7,  16'h0035, 1, 0);
    span(1397, 50, 16'h0035, 0, 0);
    span(1447, 10, 16'h0035, 1, 0);
    span(1457, 8,  16'h0036, 1, 0);
    // 0:59.9 -> 1:00.0
    span(7087, 10, 16'h0599, 1, 0);
    span(7097, 8,  16'h1000, 1, 0);
    // 9:59.9 -> DONE; start_stop at 61110 ignored; clear at 61120
    span(61087, 10, 16'h9599, 1, 0);
    span(61097, 23, 16'h0000, 0, 1);
    span(61120, 10, 16'h0000, 0, 0);
    // start at 61130, clear+start_stop at 61145, start again at 61153
    span(61130, 10, 16'h0000, 1, 0);
    span(61140, 5,  16'h0001, 1, 0);
    span(61145, 8,  16'h0000, 0, 0);
    span(61153, 2,  16'h0000, 1, 0);

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_anode",    cyc, anode,    4'b1110);
    chk("rst_code",     cyc, code,     4'd0);
    chk("rst_running",  cyc, running,  1'b0);
    chk("rst_overflow", cyc, overflow, 1'b0);
    rst = 1'b0;

    pulse_at(15,    1, 0);
    pulse_at(1030,  0, 1);
    pulse_at(1040,  1, 0);
    pulse_at(1397,  1, 0);
    pulse_at(1447,  1, 0);
    pulse_at(61110, 1, 0);
    pulse_at(61120, 0, 1);
    pulse_at(61130, 1, 0);
    pulse_at(61145, 1, 1);
    pulse_at(61153, 1, 0);
    wait_cyc(61154);

    // asynchronous reset while running with anode on position 1
    #1 rst = 1'b1;
    #1;
    chk("async_anode",   cyc, anode,   4'b1110);
    chk("async_code",    cyc, code,    4'd0);
    chk("async_running", cyc, running, 1'b0);
    span(0, 4, 16'h0000, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_cyc(5);

    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL leftover got=%0d want=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stopwatch_digit_driver.md
Name: stopwatch_digit_driver

Overview:
- Stopwatch timebase and four-digit BCD counter (M:SS.t) with multiplexed scan output.
- Produces the 4-bit digit code and active-low anode strobes that feed the board's seven-segment decoder.
- Sits between the debounced button logic and the segment decoder.
- Digit codes follow the decoder's map: 0-9 are digits, 10 is a dash, 11 is blank.

Parameters:
- CLK_HZ, 100000000, input clock frequency.
- TICK_HZ, 10, count rate (tenths of a second). Tick divisor D = CLK_HZ/TICK_HZ.
- SCAN_HZ, 1000, digit scan rate. Scan divisor S = CLK_HZ/SCAN_HZ. Requires S >= 1 and D >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start_stop  in  1  one-cycle pulse, already synchronized and debounced; toggles run/pause.
- clear  in  1  one-cycle pulse; zeroes the count.
- digit_code  out  4  code of the currently scanned digit (to the decoder data input).
- anode  out  4  one-hot active-low digit enable. anode[0] is tenths, [1] ones-seconds, [2] tens-seconds, [3] minutes.
- running  out  1  high while in RUN.
- overflow  out  1  high while in DONE.

Behaviour:
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Reset values: state IDLE; all digits 0; tick prescaler 0; scan prescaler 0; scan index 0; anode 4'b1110; digit_code 0; running 0; overflow 0.
- IDLE --start_stop--> RUN. Tick prescaler forced to 0 on that edge.
- RUN --start_stop--> PAUSE. Digits hold; prescaler holds.
- PAUSE --start_stop--> RUN. Prescaler restarts from 0.
- DONE ignores start_stop.
- clear in any state: all digits 0, prescaler 0, state IDLE.
- clear together with start_stop in the same cycle: clear wins, start_stop is dropped.
- Tick prescaler:
  - Counts 0..D-1 only in RUN.
  - In the cycle where prescaler == D-1 it wraps to 0 and the digit chain increments. The new value is visible after that edge.
  - First increment is therefore D cycles after the start_stop edge.
- Digit chain (ripple in one cycle):
  - tenths 9->0 carries to ones.
  - ones 9->0 carries to tens.
  - tens 5->0 carries to minutes.
- Terminal count: a tick at 9:59.9 does not wrap. Digits hold 9,5,9,9, state goes DONE, overflow=1 and running=0 on the next edge.
- Scan:
  - Scan prescaler counts 0..S-1 continuously in every state.
  - At S-1 the scan index advances 0->1->2->3->0.
  - anode and digit_code update on the same edge from the new index, so they are always coherent.
- Display source:
  - IDLE/RUN/PAUSE: digit_code = BCD value of the indexed digit.
  - DONE: digit_code = 10 (dash) on all positions.
- running = (state == RUN). It updates on the same edge as the state.
- Reset mid-count: immediate return to reset values, independent of clk.
- Widths: minutes and tenths/ones are 4 bits. Tens is 3 bits, zero-extended to 4 bits on output. Prescaler widths are sized by $clog2 of the divisors.

Test Plan:
1. Parameters CLK_HZ=100, TICK_HZ=10, SCAN_HZ=50 (D=10, S=2). Assert reset, then release.
   -> anode=1110, digit_code=0, running=0, overflow=0.
   -> anode rotates 1110,1101,1011,0111 every 2 cycles.
2. Pulse start_stop at cycle 0.
   -> running=1 after edge 0. Tenths becomes 1 after edge 10, 2 after edge 20.
   -> After 100 ticks the display reads 0:10.0 (codes 0,0,1,0 on anodes 0..3).
3. Pulse start_stop after 35 ticks, wait 50 cycles, pulse again.
   -> Count holds at 0:03.5 during the pause.
   -> Next increment (to 0:03.6) occurs exactly 10 cycles after the resume pulse.
4. Preload to 0:59.9 by running 599 ticks, then 1 more tick.
   -> Display 1:00.0, with ones, tens and tenths all wrapping in the same cycle.
5. Run to 9:59.9, then one more tick.
   -> State DONE, overflow=1, running=0, all digit_code=10.
   -> start_stop is ignored; clear returns to 0:00.0 in IDLE.
6. In RUN, pulse clear and start_stop in the same cycle.
   -> IDLE, count 0:00.0, running=0.
   -> Separately, assert reset mid-scan: anode=1110 immediately, before the next clk edge.
